// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: one I-cache fetch in flight, stale-response
// dropping after redirects, and a one-entry hold buffer for decode backpressure.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic        redirect,
    input  logic        stallD,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        adel,
    output logic        stallF
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDrop, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        stale_q, stale_d;

    logic aligned;
    logic go;

    assign aligned = (pc[1:0] == 2'b00);
    assign go      = pc_valid & ~redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            req_pc_q   <= RESET_PC;
            buf_inst_q <= '0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            buf_inst_q <= buf_inst_d;
            stale_q    <= stale_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        buf_inst_d = buf_inst_q;
        stale_d    = stale_q;
        ireq_valid = 1'b0;
        ireq_addr  = req_pc_q;
        inst_valid = 1'b0;
        inst       = '0;
        inst_pc    = req_pc_q;
        adel       = 1'b0;
        stallF     = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (go && aligned) begin
                    ireq_valid = 1'b1;
                    ireq_addr  = pc;
                    req_pc_d   = pc;
                    state_d    = ireq_addr_ok ? StWait : StReq;
                end else if (go) begin
                    inst_valid = 1'b1;
                    adel       = 1'b1;
                    inst_pc    = pc;
                end else begin
                    stallF = 1'b0;
                end
            end
            StReq: begin
                ireq_valid = 1'b1;
                if (redirect) stale_d = 1'b1;
                if (ireq_addr_ok) state_d = (stale_q || redirect) ? StDrop : StWait;
            end
            StWait: begin
                if (iresp_data_ok) begin
                    state_d = StIdle;
                    if (!stale_q && !redirect) begin
                        inst_valid = 1'b1;
                        inst       = iresp_data;
                        if (stallD) begin
                            buf_inst_d = iresp_data;
                            state_d    = StHold;
                        end
                    end
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (iresp_data_ok) state_d = StIdle;
            end
            StHold: begin
                inst_valid = ~redirect;
                inst       = buf_inst_q;
                if (redirect) stallF = 1'b0;
                if (!stallD || redirect) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (inst_valid && !stallD) stallF = 1'b0;
        if (state_d == StIdle) stale_d = 1'b0;

        // Outputs read as reset values during the reset cycle itself.
        if (reset) begin
            ireq_valid = 1'b0;
            ireq_addr  = RESET_PC;
            inst_valid = 1'b0;
            inst       = '0;
            inst_pc    = RESET_PC;
            adel       = 1'b0;
            stallF     = 1'b0;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: transaction-level model compared every cycle
// plus hand-computed literal expectations from the fetch scenarios.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_valid, redirect, stallD;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok, iresp_data_ok;
    logic [31:0] iresp_data;
    logic        inst_valid;
    logic [31:0] inst, inst_pc;
    logic        adel, stallF;

    int n_cmp = 0;
    int n_err = 0;

    ifetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .redirect     (redirect),
        .stallD       (stallD),
        .ireq_valid   (ireq_valid),
        .ireq_addr    (ireq_addr),
        .ireq_addr_ok (ireq_addr_ok),
        .iresp_data_ok(iresp_data_ok),
        .iresp_data   (iresp_data),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .adel         (adel),
        .stallF       (stallF)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction model: where the single outstanding fetch is in its life.
    logic        m_await_accept = 1'b0;
    logic        m_await_data   = 1'b0;
    logic        m_doomed       = 1'b0;
    logic        m_held         = 1'b0;
    logic [31:0] m_word         = '0;
    logic [31:0] m_pc           = RST_PC;

    logic        e_rv, e_iv, e_adel, e_sf;
    logic [31:0] e_addr, e_inst, e_ipc;

    always_comb begin
        e_rv = 1'b0; e_addr = '0; e_iv = 1'b0; e_inst = '0; e_ipc = m_pc;
        e_adel = 1'b0; e_sf = 1'b1;
        if (reset) begin
            e_sf  = 1'b0;
            e_ipc = RST_PC;
        end else if (m_held) begin
            e_iv   = ~redirect;
            e_inst = m_word;
            e_sf   = ~(redirect | ~stallD);
        end else if (m_await_accept) begin
            e_rv   = 1'b1;
            e_addr = m_pc;
        end else if (m_await_data) begin
            if (iresp_data_ok && !m_doomed && !redirect) begin
                e_iv   = 1'b1;
                e_inst = iresp_data;
                e_sf   = stallD;
            end
        end else if (pc_valid && !redirect) begin
            if (pc[1:0] == 2'b00) begin
                e_rv   = 1'b1;
                e_addr = pc;
            end else begin
                e_iv   = 1'b1;
                e_adel = 1'b1;
                e_ipc  = pc;
                e_sf   = stallD;
            end
        end else begin
            e_sf = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_await_accept <= 1'b0;
            m_await_data   <= 1'b0;
            m_doomed       <= 1'b0;
            m_held         <= 1'b0;
            m_word         <= '0;
            m_pc           <= RST_PC;
        end else if (m_held) begin
            if (redirect || !stallD) m_held <= 1'b0;
        end else if (m_await_accept) begin
            if (redirect) m_doomed <= 1'b1;
            if (ireq_addr_ok) begin
                m_await_accept <= 1'b0;
                m_await_data   <= 1'b1;
            end
        end else if (m_await_data) begin
            if (redirect) m_doomed <= 1'b1;
            if (iresp_data_ok) begin
                m_await_data <= 1'b0;
                m_doomed     <= 1'b0;
                if (!m_doomed && !redirect && stallD) begin
                    m_held <= 1'b1;
                    m_word <= iresp_data;
                end
            end
        end else if (pc_valid && !redirect && pc[1:0] == 2'b00) begin
            m_pc <= pc;
            if (ireq_addr_ok) m_await_data <= 1'b1;
            else m_await_accept <= 1'b1;
        end
    end

    always @(negedge clk) begin
        check("ireq_valid", {31'b0, ireq_valid}, {31'b0, e_rv});
        if (e_rv) check("ireq_addr", ireq_addr, e_addr);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, e_iv});
        if (e_iv) begin
            check("inst", inst, e_inst);
            check("inst_pc", inst_pc, e_ipc);
        end
        check("adel", {31'b0, adel}, {31'b0, e_adel});
        check("stallF", {31'b0, stallF}, {31'b0, e_sf});
    end

    task automatic drive(input logic [31:0] p, input logic pv, input logic rd, input logic sd,
                         input logic ao, input logic dok, input logic [31:0] d);
        pc = p; pc_valid = pv; redirect = rd; stallD = sd;
        ireq_addr_ok = ao; iresp_data_ok = dok; iresp_data = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lit_out(input string tag, input logic rv, input logic iv, input logic sf);
        check({tag, ".ireq_valid"}, {31'b0, ireq_valid}, {31'b0, rv});
        check({tag, ".inst_valid"}, {31'b0, inst_valid}, {31'b0, iv});
        check({tag, ".stallF"}, {31'b0, stallF}, {31'b0, sf});
    endtask

    initial begin
        reset = 1'b1;
        drive(RST_PC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        lit_out("reset", 1'b0, 1'b0, 1'b0);
        check("reset.adel", {31'b0, adel}, 32'd0);
        check("reset.inst_pc", inst_pc, RST_PC);
        tick();
        tick();
        reset = 1'b0;

        // Zero-wait fetch
        drive(32'hbfc0_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        lit_out("zw.req", 1'b1, 1'b0, 1'b1);
        check("zw.addr", ireq_addr, 32'hbfc0_0000);
        tick();
        drive(32'hbfc0_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2402_0001);
        lit_out("zw.resp", 1'b0, 1'b1, 1'b0);
        check("zw.inst", inst, 32'h2402_0001);
        check("zw.inst_pc", inst_pc, 32'hbfc0_0000);
        tick();

        // Backpressure into HOLD for three stalled cycles
        drive(32'hbfc0_0004, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(32'hbfc0_0004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2402_0001);
        lit_out("bp.resp", 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(32'hbfc0_0004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0bad_0bad);
            lit_out("bp.hold", 1'b0, 1'b1, 1'b1);
            check("bp.hold.inst", inst, 32'h2402_0001);
            check("bp.hold.inst_pc", inst_pc, 32'hbfc0_0004);
            tick();
        end
        drive(32'hbfc0_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        lit_out("bp.release", 1'b0, 1'b1, 1'b0);
        tick();

        // Fetch with one-cycle accept delay, then redirect in WAIT
        drive(32'hbfc0_0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("bp.idle_after.addr", ireq_addr, 32'hbfc0_0008);
        tick();
        drive(32'hbfc0_0008, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(32'hbfc0_0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        lit_out("rw.redirect", 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'hbfc0_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hdead_beef);
        lit_out("rw.drop", 1'b0, 1'b0, 1'b1);
        tick();
        drive(32'hbfc0_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        lit_out("rw.next", 1'b1, 1'b0, 1'b1);
        check("rw.next.addr", ireq_addr, 32'hbfc0_0100);
        tick();

        // Redirect held in REQ: request stays up unchanged, then dropped
        drive(32'hbfc0_0200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("rr.addr0", ireq_addr, 32'hbfc0_0100);
        tick();
        drive(32'hbfc0_0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        check("rr.addr1", ireq_addr, 32'hbfc0_0100);
        tick();
        drive(32'hbfc0_0200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        lit_out("rr.accept", 1'b1, 1'b0, 1'b1);
        check("rr.addr2", ireq_addr, 32'hbfc0_0100);
        tick();
        drive(32'hbfc0_0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
        lit_out("rr.drop", 1'b0, 1'b0, 1'b1);
        tick();

        // Misaligned PC
        drive(32'hbfc0_0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        lit_out("mis", 1'b0, 1'b1, 1'b0);
        check("mis.adel", {31'b0, adel}, 32'd1);
        check("mis.inst", inst, 32'd0);
        check("mis.inst_pc", inst_pc, 32'hbfc0_0002);
        tick();
        drive(32'hbfc0_0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        lit_out("idle", 1'b0, 1'b0, 1'b0);
        tick();

        // Redirect while holding
        drive(32'hbfc0_0300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(32'hbfc0_0300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
        tick();
        drive(32'hbfc0_0300, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        lit_out("rh", 1'b0, 1'b0, 1'b0);
        tick();

        // Redirect coincident with data_ok
        drive(32'hbfc0_0400, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(32'hbfc0_0400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5555_aaaa);
        lit_out("rd", 1'b0, 1'b0, 1'b1);
        tick();

        // Redirect coincident with addr_ok in REQ
        drive(32'hbfc0_0500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        drive(32'hbfc0_0500, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        tick();
        drive(32'hbfc0_0500, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
        lit_out("ra.drop", 1'b0, 1'b0, 1'b1);
        tick();

        // Reset mid-WAIT
        drive(32'hbfc0_0600, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        reset = 1'b1;
        drive(32'hbfc0_0600, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        lit_out("rst_mid", 1'b0, 1'b0, 1'b0);
        check("rst_mid.inst_pc", inst_pc, RST_PC);
        tick();
        reset = 1'b0;
        drive(32'hbfc0_0600, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        lit_out("rst_mid.next", 1'b1, 1'b0, 1'b1);
        check("rst_mid.addr", ireq_addr, 32'hbfc0_0600);
        tick();
        drive(32'hbfc0_0600, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hcafe_f00d);
        check("rst_mid.inst", inst, 32'hcafe_f00d);
        check("rst_mid.inst_pc", inst_pc, 32'hbfc0_0600);
        tick();
        drive(32'hbfc0_0604, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch front end between the PC register and the I-cache request port. Each cycle it consumes the fetch PC, issues one I-cache request per PC, returns the instruction to decode, and produces `stallF` to hold the PC register. It also discards responses made stale by a redirect, so the PC register can buffer the redirect target while `stallF` is high. Only one fetch is in flight at a time.

## Interface
Parameters
- `RESET_PC`, 32'hbfc0_0000: value of `inst_pc` after reset.

Ports
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc`  in  32  current fetch PC from the PC register.
- `pc_valid`  in  1  `pc` is fetchable. It is low for the cycle after a buffered redirect.
- `redirect`  in  1  flush or redirect this cycle. Any fetch currently in flight becomes stale.
- `stallD`  in  1  decode cannot accept an instruction this cycle.
- `ireq_valid`  out  1  I-cache request valid.
- `ireq_addr`  out  32  I-cache request address.
- `ireq_addr_ok`  in  1  request accepted this cycle.
- `iresp_data_ok`  in  1  response data valid this cycle.
- `iresp_data`  in  32  response instruction word.
- `inst_valid`  out  1  instruction offered to decode.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  PC of `inst`.
- `adel`  out  1  address-error fetch: `inst`=0 and no cache access was made.
- `stallF`  out  1  PC register must hold.

## Operation
- Registered state: FSM `{IDLE, REQ, WAIT, DROP, HOLD}`, `req_pc` (32), `buf_inst` (32), `stale` (1).
- Define `aligned = (pc[1:0]==0)` and `go = pc_valid & ~redirect`.
- IDLE
  - `go & aligned`: `ireq_valid`=1, `ireq_addr`=`pc`, and `pc` is latched into `req_pc`. If `addr_ok` arrives the same cycle, go to WAIT; otherwise go to REQ.
  - `go & ~aligned`: no request. `inst_valid`=1, `adel`=1, `inst`=0, `inst_pc`=`pc`. Stay in IDLE.
  - Otherwise: idle, no request.
- REQ
  - `ireq_valid`=1, `ireq_addr`=`req_pc`. A request cannot be withdrawn.
  - `redirect` sets `stale`.
  - On `addr_ok`: go to DROP if `stale` or `redirect`, else go to WAIT.
- WAIT
  - `data_ok & ~stale & ~redirect & ~stallD`: `inst_valid`=1, `inst`=`iresp_data` (combinational pass-through), `inst_pc`=`req_pc`, go to IDLE.
  - `data_ok & ~stale & ~redirect & stallD`: capture into `buf_inst`, go to HOLD. `inst_valid`=1 is still offered this cycle.
  - `data_ok & (stale | redirect)`: discard, go to IDLE, `inst_valid`=0.
  - `redirect` without `data_ok`: go to DROP.
- DROP: on `data_ok`, discard and go to IDLE. `inst_valid`=0 in DROP.
- HOLD
  - `inst_valid`=1, `inst`=`buf_inst`, `inst_pc`=`req_pc`.
  - `~stallD` or `redirect`: go to IDLE. `inst_valid` is forced to 0 when `redirect`=1.
- `stale` clears on every entry to IDLE.
- `stallF`
  - 0 when `inst_valid & ~stallD` (instruction consumed).
  - 0 in IDLE when `~go` (lets the PC register load `pc_valid` or the redirect target).
  - 0 in HOLD on `redirect`.
  - 1 otherwise, including REQ, WAIT, DROP, and `redirect` in those states.
- `adel`=1 only in the misaligned-IDLE case.

## Timing
- During the reset cycle and the state after reset:
  - FSM=IDLE; `stale`=0; `req_pc`=`RESET_PC`; `buf_inst`=0.
  - `ireq_valid`=0, `inst_valid`=0, `adel`=0, `stallF`=0.
- Best case is 2 cycles per instruction: request plus `addr_ok` in cycle 0, `data_ok` plus delivery in cycle 1, next PC issued in cycle 2.
- A response with `addr_ok` and `data_ok` in the same cycle is not supported. `data_ok` is honoured only in WAIT or DROP.
- `redirect` in the same cycle as `data_ok` takes priority: the response is dropped.
- `redirect` and `addr_ok` in the same cycle in REQ: go to DROP.
- Reset mid-fetch returns to IDLE. Any in-flight cache response is the cache's responsibility; the cache is reset together with this block.

## Test plan
- Zero-wait fetch: `pc`=bfc0_0000, `addr_ok` in cycle 0, `data_ok` with `iresp_data`=2402_0001 in cycle 1.
  - Required: cycle 1 has `inst_valid`=1, `inst`=2402_0001, `inst_pc`=bfc0_0000, `stallF`=0.
- Backpressure: as above but `stallD`=1 for 3 cycles.
  - Required: HOLD keeps `inst`=2402_0001 and `stallF`=1.
  - Required: the first `stallD`=0 cycle gives `stallF`=0 and the FSM returns to IDLE.
- Redirect in WAIT: `redirect` 1 cycle before `data_ok` (data=dead_beef).
  - Required: `inst_valid` stays 0 and `stallF`=1 until `data_ok`.
  - Required: IDLE afterwards, and the next request uses the new `pc`=bfc0_0100.
- Redirect held in REQ: `addr_ok` delayed 2 cycles, `redirect` in the first REQ cycle.
  - Required: `ireq_valid` stays 1 with an unchanged address.
  - Required: after `addr_ok` the FSM goes to DROP and the response is discarded.
- Misaligned PC: `pc`=bfc0_0002, `pc_valid`=1.
  - Required: `ireq_valid`=0; `inst_valid`=1, `adel`=1, `inst`=0, `inst_pc`=bfc0_0002, `stallF`=0.
- Reset mid-WAIT: assert `reset` one cycle.
  - Required: IDLE, all outputs at reset values, and the next cycle issues a fetch at the current `pc`.
